conv_addr_gen: RTL

Window address sequencer directly upstream of `engine`: walks the output feature map pixel by pixel and emits, per kernel tap, the DMA burst start addresses for data (port 2/4) and weight (port 3/5). After each pixel it emits the result burst address for port 0/1. It absorbs the stride/row-jump address logic that `engine` leaves as TODO, so `engine` only latches `data_start_addr`, `weight_start_addr` and `result_start_addr` per burst. Input data is pre-padded in DRAM; no padding logic lives here.

---
 rtl/accel_pkg.sv | 27 ++
 rtl/win_counter.sv | 91 +++++++++
 rtl/conv_addr_gen.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// accel_pkg: constants and types shared by conv_addr_gen and engine.
//   ADDR_W  - DMA address width
//   BURST   - words per pixel burst (address step per pixel/tap)
//   state_e - conv_addr_gen sequencer states
//   op_e    - engine operation types
package accel_pkg;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned BURST  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TAP     = 2'd1,
    ST_WAIT_WB = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CONV_CH0 = 3'd0,
    CONV_CH1 = 3'd1,
    CONV_CH2 = 3'd2,
    CONV_CH3 = 3'd3,
    MPOOL    = 3'd4,
    APOOL    = 3'd5
  } op_e;

endpackage

// File: rtl/win_counter.sv
// win_counter: nested kx/ky (kernel tap) and ox/oy (output pixel) counters.
//   load         - clear all counters, latch ksize/o_side limits
//   tap_adv      - step kx, then ky (wraps to tap 0 after the last tap)
//   pix_adv      - step ox, then oy
//   kx_wrap      - kx at last column of the kernel
//   tap_last     - current tap is the final tap of the pixel
//   tap_last_nxt - tap_last as it will be after this cycle's update
//   ox_wrap      - ox at last column of the output map
//   pix_last     - current pixel is the final pixel
module win_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] ksize,
  input  logic [7:0] o_side,
  input  logic       tap_adv,
  input  logic       pix_adv,
  output logic       kx_wrap,
  output logic       tap_last,
  output logic       tap_last_nxt,
  output logic       ox_wrap,
  output logic       pix_last
);

  logic [3:0] kx_q, kx_d, ky_q, ky_d, kmax_q, kmax_d;
  logic [7:0] ox_q, ox_d, oy_q, oy_d, omax_q, omax_d;
  logic       ky_wrap, oy_wrap;

  always_comb begin
    kx_wrap  = (kx_q == kmax_q);
    ky_wrap  = (ky_q == kmax_q);
    ox_wrap  = (ox_q == omax_q);
    oy_wrap  = (oy_q == omax_q);
    tap_last = kx_wrap && ky_wrap;
    pix_last = ox_wrap && oy_wrap;

    kx_d   = kx_q;
    ky_d   = ky_q;
    ox_d   = ox_q;
    oy_d   = oy_q;
    kmax_d = kmax_q;
    omax_d = omax_q;

    if (load) begin
      kx_d   = '0;
      ky_d   = '0;
      ox_d   = '0;
      oy_d   = '0;
      kmax_d = ksize - 4'd1;
      omax_d = o_side - 8'd1;
    end else begin
      if (tap_adv) begin
        if (kx_wrap) begin
          kx_d = '0;
          ky_d = ky_wrap ? '0 : ky_q + 4'd1;
        end else begin
          kx_d = kx_q + 4'd1;
        end
      end
      if (pix_adv) begin
        if (ox_wrap) begin
          ox_d = '0;
          oy_d = oy_wrap ? '0 : oy_q + 8'd1;
        end else begin
          ox_d = ox_q + 8'd1;
        end
      end
    end

    tap_last_nxt = (kx_d == kmax_d) && (ky_d == kmax_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kx_q   <= '0;
      ky_q   <= '0;
      ox_q   <= '0;
      oy_q   <= '0;
      kmax_q <= '0;
      omax_q <= '0;
    end else begin
      kx_q   <= kx_d;
      ky_q   <= ky_d;
      ox_q   <= ox_d;
      oy_q   <= oy_d;
      kmax_q <= kmax_d;
      omax_q <= omax_d;
    end
  end

endmodule

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: walks the output map pixel by pixel and emits, per kernel
// tap, data/weight DMA burst addresses, then the result burst address.
//   start/config          - job launch; config latched on start in IDLE
//   cmd_valid/cmd_ready   - tap handshake (cmd_data_addr, cmd_weight_addr,
//                           cmd_last marks final tap of the pixel)
//   wb_valid/wb_ack       - pixel writeback handshake (wb_addr)
//   busy, done            - not idle; one-cycle pulse at job end
module conv_addr_gen #(
  parameter int unsigned ADDR_W = accel_pkg::ADDR_W,
  parameter int unsigned BURST  = accel_pkg::BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] data_base,
  input  logic [ADDR_W-1:0] weight_base,
  input  logic [ADDR_W-1:0] result_base,
  input  logic [7:0]        i_side,
  input  logic [7:0]        o_side,
  input  logic [3:0]        stride,
  input  logic [3:0]        ksize,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_data_addr,
  output logic [ADDR_W-1:0] cmd_weight_addr,
  output logic              cmd_last,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_ack,
  output logic              busy,
  output logic              done
);

  import accel_pkg::*;

  typedef logic [ADDR_W-1:0] addr_t;
  localparam addr_t BURST_A = addr_t'(BURST);

  // Step sizes are formed once at launch by shift-and-add over the small
  // config factors; the per-cycle address path is adders only.
  function automatic addr_t shift_add(input addr_t a, input logic [7:0] m);
    addr_t acc;
    acc = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (m[i]) acc = acc + (a << i);
    end
    return acc;
  endfunction

  state_e state_q, state_d;
  addr_t  row_step_q, row_step_d;       // one input row
  addr_t  col_step_q, col_step_d;       // one output column (stride pixels)
  addr_t  row_jump_q, row_jump_d;       // one output row (stride input rows)
  addr_t  weight_base_q, weight_base_d;
  addr_t  pix_row_q, pix_row_d;         // tap 0 of pixel (0, oy)
  addr_t  pix_q, pix_d;                 // tap 0 of pixel (ox, oy)
  addr_t  tap_row_q, tap_row_d;         // tap (0, ky) of current pixel
  addr_t  data_q, data_d;
  addr_t  weight_q, weight_d;
  addr_t  wb_q, wb_d;
  logic   cmd_valid_q, cmd_valid_d;
  logic   cmd_last_q, cmd_last_d;
  logic   wb_valid_q, wb_valid_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;

  addr_t  row_step_in;
  logic   cnt_load, tap_adv, pix_adv;
  logic   kx_wrap, tap_last, tap_last_nxt, ox_wrap, pix_last;

  win_counter u_win_counter (
    .clk          (clk),
    .rst          (rst),
    .load         (cnt_load),
    .ksize        (ksize),
    .o_side       (o_side),
    .tap_adv      (tap_adv),
    .pix_adv      (pix_adv),
    .kx_wrap      (kx_wrap),
    .tap_last     (tap_last),
    .tap_last_nxt (tap_last_nxt),
    .ox_wrap      (ox_wrap),
    .pix_last     (pix_last)
  );

  always_comb begin
    row_step_in   = shift_add(BURST_A, i_side);
    state_d       = state_q;
    row_step_d    = row_step_q;
    col_step_d    = col_step_q;
    row_jump_d    = row_jump_q;
    weight_base_d = weight_base_q;
    pix_row_d     = pix_row_q;
    pix_d         = pix_q;
    tap_row_d     = tap_row_q;
    data_d        = data_q;
    weight_d      = weight_q;
    wb_d          = wb_q;
    cnt_load      = 1'b0;
    tap_adv       = 1'b0;
    pix_adv       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_load      = 1'b1;
          row_step_d    = row_step_in;
          col_step_d    = shift_add(BURST_A, {4'd0, stride});
          row_jump_d    = shift_add(row_step_in, {4'd0, stride});
          weight_base_d = weight_base;
          pix_row_d     = data_base;
          pix_d         = data_base;
          tap_row_d     = data_base;
          data_d        = data_base;
          weight_d      = weight_base;
          wb_d          = result_base;
          state_d       = (o_side == 8'd0 || ksize == 4'd0) ? ST_DONE : ST_TAP;
        end
      end
      ST_TAP: begin
        if (cmd_ready) begin
          tap_adv = 1'b1;
          if (tap_last) begin
            state_d = ST_WAIT_WB;
          end else if (kx_wrap) begin
            tap_row_d = tap_row_q + row_step_q;
            data_d    = tap_row_q + row_step_q;
            weight_d  = weight_q + BURST_A;
          end else begin
            data_d   = data_q + BURST_A;
            weight_d = weight_q + BURST_A;
          end
        end
      end
      ST_WAIT_WB: begin
        if (wb_ack) begin
          pix_adv = 1'b1;
          if (pix_last) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_TAP;
            wb_d     = wb_q + BURST_A;
            weight_d = weight_base_q;
            if (ox_wrap) begin
              pix_row_d = pix_row_q + row_jump_q;
              pix_d     = pix_row_q + row_jump_q;
            end else begin
              pix_d = pix_q + col_step_q;
            end
            tap_row_d = pix_d;
            data_d    = pix_d;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up
    // with the addresses registered in the same edge.
    cmd_valid_d = (state_d == ST_TAP);
    cmd_last_d  = (state_d == ST_TAP) && tap_last_nxt;
    wb_valid_d  = (state_d == ST_WAIT_WB);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      row_step_q    <= '0;
      col_step_q    <= '0;
      row_jump_q    <= '0;
      weight_base_q <= '0;
      pix_row_q     <= '0;
      pix_q         <= '0;
      tap_row_q     <= '0;
      data_q        <= '0;
      weight_q      <= '0;
      wb_q          <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_last_q    <= 1'b0;
      wb_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_step_q    <= row_step_d;
      col_step_q    <= col_step_d;
      row_jump_q    <= row_jump_d;
      weight_base_q <= weight_base_d;
      pix_row_q     <= pix_row_d;
      pix_q         <= pix_d;
      tap_row_q     <= tap_row_d;
      data_q        <= data_d;
      weight_q      <= weight_d;
      wb_q          <= wb_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_last_q    <= cmd_last_d;
      wb_valid_q    <= wb_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign cmd_valid       = cmd_valid_q;
  assign cmd_last        = cmd_last_q;
  assign cmd_data_addr   = data_q;
  assign cmd_weight_addr = weight_q;
  assign wb_valid        = wb_valid_q;
  assign wb_addr         = wb_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
